// File: rtl/register_file_ctrl.sv
// Register file with a valid/ready command port; the top register is the accumulator.
// Latency: READ data and error pulses appear 1 cycle after accept; SWAP takes 2 cycles.
// Backpressure: cmd_ready drops for the single SWAP2 cycle; otherwise every command is accepted.
module register_file_ctrl #(
   parameter int WIDTH    = 8,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [WIDTH-1:0]  cmd_wdata,
   output logic              rd_valid,
   output logic [WIDTH-1:0]  rd_data,
   output logic              cmd_err,
   input  logic              acc_we,
   input  logic [WIDTH-1:0]  acc_in,
   output logic [WIDTH-1:0]  acc_out
);

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_READ  = 3'd1;
   localparam logic [2:0] OP_WRITE = 3'd2;
   localparam logic [2:0] OP_MOVE  = 3'd3;
   localparam logic [2:0] OP_SWAP  = 3'd4;
   localparam logic [2:0] OP_CLEAR = 3'd5;

   localparam logic [ADDR_W-1:0] ACC_IDX = ADDR_W'(NUM_REGS - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SWAP2 = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_regs [NUM_REGS];
   logic [WIDTH-1:0]   r_temp;
   logic [ADDR_W-1:0]  r_swap_dst;
   logic               r_rd_valid;
   logic [WIDTH-1:0]   r_rd_data;
   logic               r_cmd_err;

   logic               w_src_ok;
   logic               w_dst_ok;
   logic [WIDTH-1:0]   w_src_val;
   logic [WIDTH-1:0]   w_dst_val;
   logic               w_wr_en;
   logic [ADDR_W-1:0]  w_wr_idx;
   logic [WIDTH-1:0]   w_wr_data;
   logic               w_ld_temp;
   logic               w_rd_load;
   logic               w_err;
   logic               w_acc_ld;

   // Indices can only be out of range when NUM_REGS is not a power of two.
   assign w_src_ok  = 32'(cmd_src) < NUM_REGS;
   assign w_dst_ok  = 32'(cmd_dst) < NUM_REGS;
   assign w_src_val = r_regs[cmd_src];
   assign w_dst_val = r_regs[cmd_dst];

   // Command decode: at most one register write per cycle through a single write port.
   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      w_wr_en     = 1'b0;
      w_wr_idx    = '0;
      w_wr_data   = '0;
      w_ld_temp   = 1'b0;
      w_rd_load   = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               case (cmd_op)
                  OP_NOP: ;
                  OP_READ: begin
                     if (!w_src_ok) w_err = 1'b1;
                     else           w_rd_load = 1'b1;
                  end
                  OP_WRITE: begin
                     if (!w_dst_ok) w_err = 1'b1;
                     else begin
                        w_wr_en   = 1'b1;
                        w_wr_idx  = cmd_dst;
                        w_wr_data = cmd_wdata;
                     end
                  end
                  OP_MOVE: begin
                     if (!w_src_ok || !w_dst_ok) w_err = 1'b1;
                     else begin
                        w_wr_en   = 1'b1;
                        w_wr_idx  = cmd_dst;
                        w_wr_data = w_src_val;
                     end
                  end
                  OP_SWAP: begin
                     if (!w_src_ok || !w_dst_ok) w_err = 1'b1;
                     else if (cmd_src != cmd_dst) begin
                        // First half: park src in temp, move dst into src.
                        w_wr_en     = 1'b1;
                        w_wr_idx    = cmd_src;
                        w_wr_data   = w_dst_val;
                        w_ld_temp   = 1'b1;
                        w_state_nxt = S_SWAP2;
                     end
                  end
                  OP_CLEAR: begin
                     if (!w_dst_ok) w_err = 1'b1;
                     else begin
                        w_wr_en   = 1'b1;
                        w_wr_idx  = cmd_dst;
                        w_wr_data = '0;
                     end
                  end
                  default: w_err = 1'b1;
               endcase
            end
         end
         S_SWAP2: begin
            // Second half: parked value lands in the original dst.
            w_wr_en     = 1'b1;
            w_wr_idx    = r_swap_dst;
            w_wr_data   = r_temp;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // The ALU load loses to any command write aimed at the accumulator.
   assign w_acc_ld = acc_we && !(w_wr_en && (w_wr_idx == ACC_IDX));

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Register array, swap holding register and read/error output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_temp     <= '0;
         r_swap_dst <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_cmd_err  <= 1'b0;
      end else begin
         if (w_wr_en)  r_regs[w_wr_idx]   <= w_wr_data;
         if (w_acc_ld) r_regs[NUM_REGS-1] <= acc_in;
         if (w_ld_temp) begin
            r_temp     <= w_src_val;
            r_swap_dst <= cmd_dst;
         end
         r_rd_valid <= w_rd_load;
         if (w_rd_load) r_rd_data <= w_src_val;
         r_cmd_err  <= w_err;
      end
   end

   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;
   assign cmd_err  = r_cmd_err;
   assign acc_out  = r_regs[NUM_REGS-1];

endmodule

// File: tb/tb_register_file_ctrl.sv
// Directed bench: vector table on an 8-register instance, hand sequences for SWAP,
// reset-in-SWAP2 and accumulator collisions, and a 6-register instance for range errors.
module tb_register_file_ctrl;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_READ  = 3'd1;
   localparam logic [2:0] OP_WRITE = 3'd2;
   localparam logic [2:0] OP_MOVE  = 3'd3;
   localparam logic [2:0] OP_SWAP  = 3'd4;
   localparam logic [2:0] OP_CLEAR = 3'd5;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic       a_cmd_valid, a_cmd_ready, a_rd_valid, a_cmd_err, a_acc_we;
   logic [2:0] a_cmd_op, a_cmd_dst, a_cmd_src;
   logic [7:0] a_cmd_wdata, a_rd_data, a_acc_in, a_acc_out;

   logic       b_cmd_valid, b_cmd_ready, b_rd_valid, b_cmd_err, b_acc_we;
   logic [2:0] b_cmd_op, b_cmd_dst, b_cmd_src;
   logic [7:0] b_cmd_wdata, b_rd_data, b_acc_in, b_acc_out;

   register_file_ctrl #(.WIDTH(8), .NUM_REGS(8)) u_a (
      .clk(clk), .rst(rst),
      .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_op(a_cmd_op),
      .cmd_dst(a_cmd_dst), .cmd_src(a_cmd_src), .cmd_wdata(a_cmd_wdata),
      .rd_valid(a_rd_valid), .rd_data(a_rd_data), .cmd_err(a_cmd_err),
      .acc_we(a_acc_we), .acc_in(a_acc_in), .acc_out(a_acc_out)
   );

   register_file_ctrl #(.WIDTH(8), .NUM_REGS(6)) u_b (
      .clk(clk), .rst(rst),
      .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
      .cmd_dst(b_cmd_dst), .cmd_src(b_cmd_src), .cmd_wdata(b_cmd_wdata),
      .rd_valid(b_rd_valid), .rd_data(b_rd_data), .cmd_err(b_cmd_err),
      .acc_we(b_acc_we), .acc_in(b_acc_in), .acc_out(b_acc_out)
   );

   typedef struct {
      logic       vld;
      logic [2:0] op;
      logic [2:0] dst;
      logic [2:0] src;
      logic [7:0] wd;
      logic       awe;
      logic [7:0] ain;
      logic       e_rv;
      logic [7:0] e_rd;
      logic       e_err;
      logic       e_rdy;
      logic [7:0] e_acc;
   } vec_t;

   vec_t tbl [30];
   int   n_chk = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic vld, input logic [2:0] op, input logic [2:0] dst,
                               input logic [2:0] src, input logic [7:0] wd, input logic awe,
                               input logic [7:0] ain, input logic e_rv, input logic [7:0] e_rd,
                               input logic e_err, input logic e_rdy, input logic [7:0] e_acc);
      vec_t v;
      v.vld = vld; v.op = op; v.dst = dst; v.src = src; v.wd = wd; v.awe = awe; v.ain = ain;
      v.e_rv = e_rv; v.e_rd = e_rd; v.e_err = e_err; v.e_rdy = e_rdy; v.e_acc = e_acc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive one cycle on instance A at the falling edge, then sample just after the rising edge.
   task automatic a_cmd(input logic v, input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                        input logic [7:0] wd, input logic we, input logic [7:0] ai);
      @(negedge clk);
      a_cmd_valid = v; a_cmd_op = op; a_cmd_dst = dst; a_cmd_src = src;
      a_cmd_wdata = wd; a_acc_we = we; a_acc_in = ai;
      @(posedge clk);
      #1;
   endtask

   task automatic b_cmd(input logic v, input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                        input logic [7:0] wd);
      @(negedge clk);
      b_cmd_valid = v; b_cmd_op = op; b_cmd_dst = dst; b_cmd_src = src;
      b_cmd_wdata = wd; b_acc_we = 1'b0; b_acc_in = 8'h00;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      a_cmd_valid = 0; a_cmd_op = 0; a_cmd_dst = 0; a_cmd_src = 0; a_cmd_wdata = 0; a_acc_we = 0; a_acc_in = 0;
      b_cmd_valid = 0; b_cmd_op = 0; b_cmd_dst = 0; b_cmd_src = 0; b_cmd_wdata = 0; b_acc_we = 0; b_acc_in = 0;

      // Vector table: {vld, op, dst, src, wdata, acc_we, acc_in} -> {rd_valid, rd_data, err, ready, acc_out}
      for (int i = 0; i < 8; i++)
         tbl[i] = mk(1, OP_READ, 0, 3'(i), 8'h00, 0, 8'h00, 1, 8'h00, 0, 1, 8'h00);
      tbl[8]  = mk(1, OP_WRITE, 2, 0, 8'hA5, 0, 8'h00, 0, 8'h00, 0, 1, 8'h00);
      tbl[9]  = mk(1, OP_READ,  0, 2, 8'h00, 0, 8'h00, 1, 8'hA5, 0, 1, 8'h00);
      tbl[10] = mk(1, OP_WRITE, 2, 0, 8'h3C, 0, 8'h00, 0, 8'hA5, 0, 1, 8'h00);
      tbl[11] = mk(1, OP_READ,  0, 2, 8'h00, 0, 8'h00, 1, 8'h3C, 0, 1, 8'h00);
      tbl[12] = mk(1, OP_WRITE, 7, 0, 8'h5A, 0, 8'h00, 0, 8'h3C, 0, 1, 8'h5A);
      tbl[13] = mk(1, OP_READ,  0, 7, 8'h00, 1, 8'h3C, 1, 8'h5A, 0, 1, 8'h3C);  // old value while loaded
      tbl[14] = mk(1, OP_READ,  0, 7, 8'h00, 0, 8'h00, 1, 8'h3C, 0, 1, 8'h3C);
      tbl[15] = mk(1, OP_WRITE, 7, 0, 8'h01, 1, 8'h7E, 0, 8'h3C, 0, 1, 8'h01);  // command beats acc_we
      tbl[16] = mk(1, OP_NOP,   0, 0, 8'h00, 1, 8'h7E, 0, 8'h3C, 0, 1, 8'h7E);
      tbl[17] = mk(1, OP_MOVE,  4, 2, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 1, 8'h7E);
      tbl[18] = mk(1, OP_READ,  0, 4, 8'h00, 0, 8'h00, 1, 8'h3C, 0, 1, 8'h7E);
      tbl[19] = mk(1, OP_CLEAR, 4, 0, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 1, 8'h7E);
      tbl[20] = mk(1, OP_READ,  0, 4, 8'h00, 0, 8'h00, 1, 8'h00, 0, 1, 8'h7E);
      tbl[21] = mk(1, OP_MOVE,  2, 2, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 8'h7E);
      tbl[22] = mk(1, OP_READ,  0, 2, 8'h00, 0, 8'h00, 1, 8'h3C, 0, 1, 8'h7E);
      tbl[23] = mk(1, OP_SWAP,  2, 2, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 1, 8'h7E);  // src==dst: stays IDLE
      tbl[24] = mk(1, OP_READ,  0, 2, 8'h00, 0, 8'h00, 1, 8'h3C, 0, 1, 8'h7E);
      tbl[25] = mk(1, 3'd6,     2, 2, 8'hFF, 0, 8'h00, 0, 8'h3C, 1, 1, 8'h7E);
      tbl[26] = mk(0, OP_WRITE, 2, 0, 8'hFF, 0, 8'h00, 0, 8'h3C, 0, 1, 8'h7E);  // not valid: ignored
      tbl[27] = mk(1, OP_READ,  0, 2, 8'h00, 0, 8'h00, 1, 8'h3C, 0, 1, 8'h7E);
      tbl[28] = mk(1, 3'd7,     7, 0, 8'h00, 0, 8'h00, 0, 8'h3C, 1, 1, 8'h7E);
      tbl[29] = mk(1, OP_MOVE,  7, 4, 8'h00, 1, 8'h55, 0, 8'h3C, 0, 1, 8'h00);  // MOVE beats acc_we

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst ready",    32'(a_cmd_ready), 32'd1);
      chk("rst rd_valid", 32'(a_rd_valid),  32'd0);
      chk("rst rd_data",  32'(a_rd_data),   32'h00);
      chk("rst err",      32'(a_cmd_err),   32'd0);
      chk("rst acc",      32'(a_acc_out),   32'h00);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 30; i++) begin
         a_cmd(tbl[i].vld, tbl[i].op, tbl[i].dst, tbl[i].src, tbl[i].wd, tbl[i].awe, tbl[i].ain);
         chk($sformatf("v%0d rd_valid", i), 32'(a_rd_valid),  32'(tbl[i].e_rv));
         chk($sformatf("v%0d rd_data", i),  32'(a_rd_data),   32'(tbl[i].e_rd));
         chk($sformatf("v%0d err", i),      32'(a_cmd_err),   32'(tbl[i].e_err));
         chk($sformatf("v%0d ready", i),    32'(a_cmd_ready), 32'(tbl[i].e_rdy));
         chk($sformatf("v%0d acc", i),      32'(a_acc_out),   32'(tbl[i].e_acc));
      end

      // SWAP r1<->r3 with a READ r3 held behind it; acc_we during SWAP2 does not collide.
      a_cmd(1, OP_WRITE, 1, 0, 8'h11, 0, 8'h00);
      a_cmd(1, OP_WRITE, 3, 0, 8'h33, 0, 8'h00);
      a_cmd(1, OP_SWAP,  3, 1, 8'h00, 0, 8'h00);
      chk("swap1 ready low", 32'(a_cmd_ready), 32'd0);
      a_cmd(1, OP_READ,  0, 3, 8'h00, 1, 8'h42);
      chk("swap1 held not taken", 32'(a_rd_valid), 32'd0);
      chk("swap1 ready back",     32'(a_cmd_ready), 32'd1);
      chk("swap1 acc in SWAP2",   32'(a_acc_out),   32'h42);
      a_cmd(1, OP_READ,  0, 3, 8'h00, 0, 8'h00);
      chk("swap1 held rd_valid", 32'(a_rd_valid), 32'd1);
      chk("swap1 r3",            32'(a_rd_data),  32'h11);
      a_cmd(1, OP_READ,  0, 1, 8'h00, 0, 8'h00);
      chk("swap1 r1",            32'(a_rd_data),  32'h33);

      // SWAP r1<->acc: acc_we honoured on the accept edge, dropped against the SWAP2 write.
      a_cmd(1, OP_WRITE, 7, 0, 8'hC7, 0, 8'h00);
      chk("swap2 acc pre", 32'(a_acc_out), 32'hC7);
      a_cmd(1, OP_SWAP,  7, 1, 8'h00, 1, 8'h24);
      chk("swap2 acc accept", 32'(a_acc_out), 32'h24);
      a_cmd(0, OP_NOP,   0, 0, 8'h00, 1, 8'hEE);
      chk("swap2 acc SWAP2",  32'(a_acc_out), 32'h33);
      a_cmd(1, OP_READ,  0, 1, 8'h00, 0, 8'h00);
      chk("swap2 r1", 32'(a_rd_data), 32'hC7);

      // Reset while in SWAP2: takes effect immediately, no partial swap survives.
      a_cmd(1, OP_WRITE, 1, 0, 8'h11, 0, 8'h00);
      a_cmd(1, OP_WRITE, 3, 0, 8'h33, 0, 8'h00);
      a_cmd(1, OP_SWAP,  3, 1, 8'h00, 0, 8'h00);
      chk("rswap in SWAP2", 32'(a_cmd_ready), 32'd0);
      a_cmd_valid = 1'b0;
      rst = 1'b1;
      #2;
      chk("rswap ready",    32'(a_cmd_ready), 32'd1);
      chk("rswap acc",      32'(a_acc_out),   32'h00);
      chk("rswap rd_data",  32'(a_rd_data),   32'h00);
      @(negedge clk);
      rst = 1'b0;
      a_cmd(1, OP_READ, 0, 1, 8'h00, 0, 8'h00);
      chk("rswap r1 valid", 32'(a_rd_valid), 32'd1);
      chk("rswap r1",       32'(a_rd_data),  32'h00);
      a_cmd(1, OP_READ, 0, 3, 8'h00, 0, 8'h00);
      chk("rswap r3",       32'(a_rd_data),  32'h00);
      a_cmd(1, OP_READ, 0, 2, 8'h00, 0, 8'h00);
      chk("rswap r2",       32'(a_rd_data),  32'h00);
      a_cmd(0, OP_NOP, 0, 0, 8'h00, 0, 8'h00);

      // NUM_REGS=6: out-of-range indices and illegal ops.
      b_cmd(1, OP_WRITE, 5, 0, 8'h5F);
      chk("b acc load", 32'(b_acc_out), 32'h5F);
      b_cmd(1, OP_READ, 0, 5, 8'h00);
      chk("b read acc", 32'(b_rd_data), 32'h5F);
      b_cmd(1, OP_READ, 0, 6, 8'h00);
      chk("b rd6 err",   32'(b_cmd_err),  32'd1);
      chk("b rd6 valid", 32'(b_rd_valid), 32'd0);
      chk("b rd6 data",  32'(b_rd_data),  32'h5F);
      b_cmd(0, OP_NOP, 0, 0, 8'h00);
      chk("b err cleared 1", 32'(b_cmd_err), 32'd0);
      b_cmd(1, OP_WRITE, 7, 0, 8'hAA);
      chk("b wr7 err",   32'(b_cmd_err),  32'd1);
      chk("b wr7 valid", 32'(b_rd_valid), 32'd0);
      b_cmd(0, OP_NOP, 0, 0, 8'h00);
      chk("b err cleared 2", 32'(b_cmd_err), 32'd0);
      b_cmd(1, 3'd7, 0, 0, 8'h00);
      chk("b op7 err", 32'(b_cmd_err), 32'd1);
      b_cmd(1, OP_MOVE, 5, 6, 8'h00);
      chk("b move err", 32'(b_cmd_err), 32'd1);
      chk("b move acc", 32'(b_acc_out), 32'h5F);
      b_cmd(1, OP_SWAP, 7, 0, 8'h00);
      chk("b swap err",   32'(b_cmd_err),   32'd1);
      chk("b swap ready", 32'(b_cmd_ready), 32'd1);
      for (int i = 0; i < 5; i++) begin
         b_cmd(1, OP_READ, 0, 3'(i), 8'h00);
         chk($sformatf("b r%0d valid", i), 32'(b_rd_valid), 32'd1);
         chk($sformatf("b r%0d", i),       32'(b_rd_data),  32'h00);
      end
      chk("b acc final", 32'(b_acc_out), 32'h5F);
      b_cmd(0, OP_NOP, 0, 0, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
